// File: rtl/rv_pkg.sv
// Shared writeback definitions.
//   t_ld_size  : load access size (byte/half/word/double)
//   SEL_*      : writeback source select encodings
//   t_wb_state : writeback stage state (idle / waiting on memory)
package rv_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } t_ld_size;

  localparam int unsigned SEL_ALU_RESULT   = 0;
  localparam int unsigned SEL_DMEM_RD_DATA = 1;
  localparam int unsigned SEL_PC_PLUS4     = 2;
  localparam int unsigned SEL_CSR_RD_DATA  = 3;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } t_wb_state;

endpackage

// File: rtl/rv_ld_align.sv
// Load data alignment: shifts the raw memory word down to the addressed
// byte lane, keeps the access-size bits and sign- or zero-extends them.
// Purely combinational.
//   data     : raw aligned-word load data
//   size     : access size
//   is_unsig : zero-extend when set
//   addr_lsb : byte offset within the word
//   result   : extended load value
module rv_ld_align
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] data,
  input  t_ld_size        size,
  input  logic            is_unsig,
  input  logic [AW-1:0]   addr_lsb,
  output logic [XLEN-1:0] result
);

  logic [AW-1:0]   off;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] mask;
  logic            sbit;

  // Offset bits below the access size are ignored (natural alignment).
  always_comb begin
    off = addr_lsb;
    unique case (size)
      LD_B:    off = addr_lsb;
      LD_H:    off = addr_lsb & ~AW'(1);
      LD_W:    off = addr_lsb & ~AW'(3);
      default: off = '0;
    endcase
  end

  assign sh = data >> {off, 3'b000};

  // A mask covering the full width leaves nothing to extend, so word loads
  // on a 32-bit datapath are unaffected by is_unsig.
  always_comb begin
    mask = '1;
    sbit = sh[XLEN-1];
    unique case (size)
      LD_B: begin
        mask = XLEN'({8{1'b1}});
        sbit = sh[7];
      end
      LD_H: begin
        mask = XLEN'({16{1'b1}});
        sbit = sh[15];
      end
      LD_W: begin
        mask = XLEN'({32{1'b1}});
        sbit = sh[31];
      end
      default: begin
        mask = '1;
        sbit = sh[XLEN-1];
      end
    endcase
  end

  assign result = (sh & mask) | ((sbit & ~is_unsig) ? ~mask : '0);

endmodule

// File: rtl/rv_wb_unit.sv
// Writeback stage. Selects the Q104H result, aligns load data, stalls the
// pipeline while a data-memory response is outstanding and drives a
// registered register-file write port in Q105H.
//   clk, rst          : clock, synchronous active-high reset
//   *_Q104H           : instruction in writeback (held stable while stalled)
//   dmem_rsp_valid    : load data valid this cycle
//   dmem_rd_data      : raw load data
//   wb_stall          : freeze Q104H and earlier stages (combinational)
//   rf_wr_*_Q105H     : register-file write port
//   load_timeout      : sticky flag, a load gave up waiting for memory
module rv_wb_unit
  import rv_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned LOAD_SRC      = SEL_DMEM_RD_DATA,
  parameter int unsigned MAX_LOAD_WAIT = 15,
  parameter int unsigned SW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int unsigned AW            = $clog2(XLEN/8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_Q104H,
  input  logic [SW-1:0]           sel_wb_Q104H,
  input  logic [NUM_SRC*XLEN-1:0] src_data_Q104H,
  input  logic                    rf_wr_en_Q104H,
  input  logic [4:0]              rd_Q104H,
  input  logic [1:0]              ld_size_Q104H,
  input  logic                    ld_unsigned_Q104H,
  input  logic [AW-1:0]           addr_lsb_Q104H,
  input  logic                    dmem_rsp_valid,
  input  logic [XLEN-1:0]         dmem_rd_data,
  output logic                    wb_stall,
  output logic                    rf_wr_en_Q105H,
  output logic [4:0]              rf_wr_addr_Q105H,
  output logic [XLEN-1:0]         rf_wr_data_Q105H,
  output logic                    load_timeout
);

  localparam int unsigned CW = (MAX_LOAD_WAIT > 0) ? $clog2(MAX_LOAD_WAIT + 1) : 1;

  t_wb_state       state;
  logic [CW-1:0]   cnt;
  logic            is_load;
  logic            cnt_max;
  logic            wr_q;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wb_data;

  assign is_load = valid_Q104H & (32'(sel_wb_Q104H) == LOAD_SRC);
  assign cnt_max = (cnt == CW'(MAX_LOAD_WAIT));
  assign wr_q    = rf_wr_en_Q104H & (rd_Q104H != 5'd0);

  rv_ld_align #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_ld_align (
    .data     (dmem_rd_data),
    .size     (t_ld_size'(ld_size_Q104H)),
    .is_unsig (ld_unsigned_Q104H),
    .addr_lsb (addr_lsb_Q104H),
    .result   (ld_data)
  );

  // Load slot always takes memory data; selects past NUM_SRC yield zero.
  always_comb begin
    wb_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(sel_wb_Q104H) == i) wb_data = src_data_Q104H[i*XLEN +: XLEN];
    end
    if (32'(sel_wb_Q104H) == LOAD_SRC) wb_data = ld_data;
  end

  assign wb_stall = ((state == WB_IDLE) & is_load & ~dmem_rsp_valid) |
                    ((state == WB_WAIT) & ~dmem_rsp_valid & ~cnt_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= WB_IDLE;
      cnt              <= '0;
      rf_wr_en_Q105H   <= 1'b0;
      rf_wr_addr_Q105H <= '0;
      rf_wr_data_Q105H <= '0;
      load_timeout     <= 1'b0;
    end else begin
      rf_wr_en_Q105H <= 1'b0;
      unique case (state)
        WB_IDLE: begin
          if (valid_Q104H) begin
            if (is_load & ~dmem_rsp_valid) begin
              state <= WB_WAIT;
              cnt   <= '0;
            end else begin
              rf_wr_en_Q105H   <= wr_q;
              rf_wr_addr_Q105H <= rd_Q104H;
              rf_wr_data_Q105H <= wb_data;
            end
          end
        end
        WB_WAIT: begin
          // A response in the timeout cycle takes priority over the timeout.
          if (dmem_rsp_valid) begin
            state            <= WB_IDLE;
            rf_wr_en_Q105H   <= valid_Q104H & wr_q;
            rf_wr_addr_Q105H <= rd_Q104H;
            rf_wr_data_Q105H <= wb_data;
          end else if (cnt_max) begin
            state            <= WB_IDLE;
            rf_wr_en_Q105H   <= valid_Q104H & wr_q;
            rf_wr_addr_Q105H <= rd_Q104H;
            rf_wr_data_Q105H <= '0;
            load_timeout     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv_wb_unit.md
# rv_wb_unit

Parametrised writeback stage: selects the result among `NUM_SRC` Q104H sources and aligns and sign/zero-extends load data by size and address offset. It absorbs variable-latency data-memory responses by stalling the pipeline, and drives a registered register-file write port in Q105H. It sits between the memory stage and the register file, with a load-wait timeout flag for debug.

## Interface
- `XLEN`, 32: datapath width, 32 or 64.
- `NUM_SRC`, 4: number of writeback sources.
- `LOAD_SRC`, 1: source index that carries load data; it selects `dmem_rd_data`, never `src_data_Q104H[LOAD_SRC]`.
- `MAX_LOAD_WAIT`, 15: stall cycles before load timeout.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `valid_Q104H` in 1: instruction present in WB.
- `sel_wb_Q104H` in $clog2(NUM_SRC): source select.
- `src_data_Q104H` in NUM_SRC×XLEN: packed source data.
- `rf_wr_en_Q104H` in 1: instruction writes rd.
- `rd_Q104H` in 5: destination register.
- `ld_size_Q104H` in 2: 0 byte, 1 half, 2 word, 3 double (legal only for XLEN=64).
- `ld_unsigned_Q104H` in 1: zero-extend when set.
- `addr_lsb_Q104H` in $clog2(XLEN/8): load byte offset.
- `dmem_rsp_valid` in 1: load data valid this cycle.
- `dmem_rd_data` in XLEN: raw aligned-word load data.
- `wb_stall` out 1: freeze Q104H and all earlier stages.
- `rf_wr_en_Q105H` out 1: register-file write enable.
- `rf_wr_addr_Q105H` out 5: write address.
- `rf_wr_data_Q105H` out XLEN: write data.
- `load_timeout` out 1: sticky, set on load timeout.

## Operation
- A load is defined as `valid_Q104H & sel_wb_Q104H==LOAD_SRC`.
- **IDLE, non-load valid:** capture the selected source and rd into Q105H next edge. Stall stays 0.
- **IDLE, load with `dmem_rsp_valid`=1:** complete in the same cycle; no stall.
- **IDLE, load with `dmem_rsp_valid`=0:** assert `wb_stall`, go to WAIT, clear the wait counter.
- **WAIT:** `wb_stall` stays asserted. Upstream holds all Q104H inputs stable. The counter increments every cycle.
  - On `dmem_rsp_valid`: write the extended data, drop the stall, return to IDLE.
  - If the counter reaches `MAX_LOAD_WAIT` with no response: drop the stall, write 0 to rd, set `load_timeout`, return to IDLE.
- **Load extraction:** shift `dmem_rd_data` right by `8*addr_lsb`. Low offset bits are ignored for the access size: half ignores bit 0, word ignores bits [1:0], double ignores all. Keep `8<<ld_size` bits, then sign-extend from the top kept bit unless `ld_unsigned_Q104H`. For word loads on XLEN=32 the unsigned bit has no effect.
- **x0 suppression:** `rf_wr_en_Q105H` = `valid & rf_wr_en_Q104H & (rd!=0)` at completion.
- **Unused sources:** `sel_wb_Q104H` ≥ NUM_SRC selects 0.
- **Stray responses:** `dmem_rsp_valid` in IDLE without a load is ignored.
- **Reset mid-WAIT:** go to IDLE with no write; `load_timeout` is cleared.
- `rf_wr_en_Q105H` is a one-cycle pulse per completed instruction. It is 0 in every stall cycle.

## Timing
- **Reset values:** state IDLE, counter 0. `rf_wr_en_Q105H`=0, `rf_wr_addr_Q105H`=0, `rf_wr_data_Q105H`=0, `load_timeout`=0.
- **Latency:**
  - Non-load and zero-wait load: 1 cycle, Q104H to Q105H.
  - Waited load: written on the edge after the `dmem_rsp_valid` cycle.
- **`wb_stall` is combinational:** `(IDLE & load & ~dmem_rsp_valid) | (WAIT & ~dmem_rsp_valid & ~(cnt==MAX_LOAD_WAIT))`. It depends on no registered output.
- **Timeout timing:** a response arriving in the same cycle as the timeout wins. Data is written and `load_timeout` is not set.
- **Maximum stall:** `MAX_LOAD_WAIT`+1 cycles per load.

## Structure
- **Shared package `rv_pkg`:**
  - `t_ld_size` enum (LD_B, LD_H, LD_W, LD_D).
  - Writeback select constants; SEL_DMEM_RD_DATA equals the default `LOAD_SRC`.
  - `t_wb_state` (WB_IDLE, WB_WAIT).
- **Sub-module `rv_ld_align`:** purely combinational shift/mask/extend, parametrised by XLEN, unit-testable alone.
- **Flops:** use the codebase DFF macros with synchronous reset.

## Test plan
- **Non-load:** valid, sel=0, src0=0x1234_5678, rd=5 -> next cycle wr_en=1, addr=5, data=0x1234_5678, stall never 1.
- **Signed byte:** load LB, lsb=3, rsp same cycle with data 0x80AB_CDEF -> data 0xFFFF_FF80. LBU with the same stimulus -> 0x0000_0080.
- **Signed half:** LH lsb=2, data 0x8001_7FFF -> 0xFFFF_8001.
- **Waited load:** response delayed 3 cycles -> stall high exactly 3 cycles, single write pulse with data on the cycle after the response.
- **Timeout:** no response -> stall high `MAX_LOAD_WAIT`+1 cycles, then write 0 and `load_timeout`=1 (sticky). Response on the last cycle instead -> data written, flag stays 0.
- **x0, stray response, reset:** rd=0 non-load -> wr_en stays 0. Stray `dmem_rsp_valid` in IDLE -> no write. `rst` asserted during WAIT -> next cycle stall=0, wr_en=0, state IDLE.
